// File: rtl/pic_core_param_pkg.sv
// Shared types, opcode constants and the instruction decoder for the
// parametrised PIC-style core.
package pic_pkg;

    typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_WB} state_e;

    typedef enum logic [3:0] {
        ADD, SUB, AND, PASS, INC, DEC, CLR, COM, BCLR, BSET
    } alu_op_e;

    typedef enum logic [1:0] {SRC_F, SRC_K, SRC_W} src_e;

    localparam logic [5:0] OP_ADDWF  = 6'b000111;
    localparam logic [5:0] OP_SUBWF  = 6'b000010;
    localparam logic [5:0] OP_ANDWF  = 6'b000101;
    localparam logic [5:0] OP_MOVF   = 6'b001000;
    localparam logic [5:0] OP_COMF   = 6'b001001;
    localparam logic [5:0] OP_INCF   = 6'b001010;
    localparam logic [5:0] OP_DECF   = 6'b000011;
    localparam logic [5:0] OP_DECFSZ = 6'b001011;
    localparam logic [5:0] OP_INCFSZ = 6'b001111;
    localparam logic [5:0] OP_MOVLW  = 6'b110000;
    localparam logic [5:0] OP_ADDLW  = 6'b111110;
    localparam logic [6:0] OP_CLRF   = 7'b0000011;
    localparam logic [6:0] OP_CLRW   = 7'b0000010;
    localparam logic [6:0] OP_MOVWF  = 7'b0000001;
    localparam logic [1:0] OP_BITS   = 2'b01;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_GOTO   = 3'b101;
    localparam logic [13:0] INSN_RETURN = 14'b00000000001000;
    localparam logic [13:0] INSN_NOP    = 14'b00000000000000;

    typedef struct packed {
        alu_op_e op;
        src_e    src;
        logic    wr_w;
        logic    wr_f;
        logic    upd_z;
        logic    upd_c;
        logic    fsz;
        logic    btst;
        logic    skip_if_set;
        logic    jump;
        logic    call;
        logic    ret;
    } ctl_t;

    // Anything not matched below stays all-zero controls, i.e. a NOP.
    function automatic ctl_t decode(input logic [13:0] ir);
        ctl_t c;
        logic d;
        c     = '0;
        c.op  = PASS;
        c.src = SRC_F;
        d     = ir[7];
        if (ir[13:11] == OP_CALL || ir[13:11] == OP_GOTO) begin
            c.jump = 1'b1;
            c.call = (ir[13:11] == OP_CALL);
        end else if (ir[13:12] == OP_BITS) begin
            case (ir[11:10])
                2'b00:   begin c.op = BCLR; c.wr_f = 1'b1; end
                2'b01:   begin c.op = BSET; c.wr_f = 1'b1; end
                2'b10:   c.btst = 1'b1;
                default: begin c.btst = 1'b1; c.skip_if_set = 1'b1; end
            endcase
        end else if (ir == INSN_RETURN) begin
            c.ret = 1'b1;
        end else begin
            case (ir[13:8])
                OP_ADDWF:  begin c.op = ADD;  c.upd_z = 1'b1; c.upd_c = 1'b1; end
                OP_SUBWF:  begin c.op = SUB;  c.upd_z = 1'b1; c.upd_c = 1'b1; end
                OP_ANDWF:  begin c.op = AND;  c.upd_z = 1'b1; end
                OP_MOVF:   begin c.op = PASS; c.upd_z = 1'b1; end
                OP_COMF:   begin c.op = COM;  c.upd_z = 1'b1; end
                OP_INCF:   begin c.op = INC;  c.upd_z = 1'b1; end
                OP_DECF:   begin c.op = DEC;  c.upd_z = 1'b1; end
                OP_DECFSZ: begin c.op = DEC;  c.fsz = 1'b1; end
                OP_INCFSZ: begin c.op = INC;  c.fsz = 1'b1; end
                OP_MOVLW:  begin c.op = PASS; c.src = SRC_K; c.wr_w = 1'b1; end
                OP_ADDLW:  begin
                    c.op = ADD; c.src = SRC_K; c.wr_w = 1'b1;
                    c.upd_z = 1'b1; c.upd_c = 1'b1;
                end
                default: begin
                    case (ir[13:7])
                        OP_CLRF:  begin c.op = CLR; c.wr_f = 1'b1; c.upd_z = 1'b1; end
                        OP_CLRW:  begin c.op = CLR; c.wr_w = 1'b1; c.upd_z = 1'b1; end
                        OP_MOVWF: begin c.op = PASS; c.src = SRC_W; c.wr_f = 1'b1; end
                        default:  ;
                    endcase
                end
            endcase
            // The byte-oriented file ops pick their destination from d.
            if (!c.wr_w && !c.wr_f && c.src == SRC_F && (c.upd_z || c.fsz)) begin
                c.wr_w = ~d;
                c.wr_f = d;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/pic_core_param_if.sv
// Core-facing bus: ROM fetch port plus the observation outputs.
interface pic_core_param_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 11
);
    logic [PC_W-1:0]   rom_addr;
    logic [13:0]       rom_data;
    logic [DATA_W-1:0] w_q;
    logic [PC_W-1:0]   pc_q;
    logic              status_z;
    logic              status_c;
    logic              stack_err;
    logic              retire;

    modport master (
        output rom_addr, w_q, pc_q, status_z, status_c, stack_err, retire,
        input  rom_data
    );

    modport slave (
        input  rom_addr, w_q, pc_q, status_z, status_c, stack_err, retire,
        output rom_data
    );
endinterface

// File: rtl/pic_core_param_call_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pic_call_stack #(
    parameter int PC_W        = 11,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            err
);
    localparam int IW = $clog2(STACK_DEPTH);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [IW-1:0]   wp_q;
    logic [CW-1:0]   cnt_q;
    logic            err_q;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == IW'(STACK_DEPTH - 1)) ? '0 : i + IW'(1);
    endfunction

    function automatic logic [IW-1:0] wrap_dec(input logic [IW-1:0] i);
        return (i == '0) ? IW'(STACK_DEPTH - 1) : i - IW'(1);
    endfunction

    assign top   = mem[wrap_dec(wp_q)];
    assign empty = (cnt_q == '0);
    assign err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (push) begin
            wp_q <= wrap_inc(wp_q);
            if (cnt_q == CW'(STACK_DEPTH)) err_q <= 1'b1;
            else                           cnt_q <= cnt_q + CW'(1);
        end else if (pop) begin
            if (empty) begin
                err_q <= 1'b1;
            end else begin
                wp_q  <= wrap_dec(wp_q);
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wp_q] <= push_data;
    end
endmodule

// File: rtl/pic_core_param.sv
// Four-clock multicycle PIC-style core: fetch, decode, execute, writeback.
module pic_core_param
    import pic_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 11,
    parameter int RAM_AW      = 7,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    pic_core_param_if.master  bus
);
    state_e            state_q, state_d;
    logic              do_fetch, do_decode, do_exec, do_wb;
    logic [PC_W-1:0]   pc_q, mar_q;
    logic [13:0]       ir_q;
    logic [DATA_W-1:0] w_q, res_q;
    logic              z_q, c_q, skip_q, cy_q, skp_q;
    logic [DATA_W-1:0] ram [2**RAM_AW];

    ctl_t              ctl;
    logic [RAM_AW-1:0] fa;
    logic [2:0]        bsel;
    logic [DATA_W-1:0] fval, kval, opnd, bmask, res;
    logic              cy, skp;
    logic [PC_W-1:0]   stk_top;
    logic              stk_empty, stk_err;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_RST;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_RST;
        endcase
    end

    always_comb begin
        do_fetch  = 1'b0;
        do_decode = 1'b0;
        do_exec   = 1'b0;
        do_wb     = 1'b0;
        case (state_q)
            S_FETCH:  do_fetch  = 1'b1;
            S_DECODE: do_decode = 1'b1;
            S_EXEC:   do_exec   = 1'b1;
            S_WB:     do_wb     = 1'b1;
            default:  ;
        endcase
    end

    // IR is stable from decode through writeback, so one decoder serves both.
    assign ctl  = decode(ir_q);
    assign fa   = ir_q[RAM_AW-1:0];
    assign bsel = ir_q[9:7];
    assign fval = ram[fa];
    assign kval = DATA_W'(ir_q[7:0]);

    always_comb begin
        case (ctl.src)
            SRC_K:   opnd = kval;
            SRC_W:   opnd = w_q;
            default: opnd = fval;
        endcase
        bmask = DATA_W'(1) << bsel;
        res   = opnd;
        cy    = 1'b0;
        case (ctl.op)
            ADD:  {cy, res} = {1'b0, opnd} + {1'b0, w_q};
            SUB:  begin res = opnd - w_q; cy = (opnd >= w_q); end
            AND:  res = opnd & w_q;
            INC:  res = opnd + DATA_W'(1);
            DEC:  res = opnd - DATA_W'(1);
            CLR:  res = '0;
            COM:  res = ~opnd;
            BCLR: res = opnd & ~bmask;
            BSET: res = opnd | bmask;
            default: res = opnd;
        endcase
        skp = ctl.btst ? (opnd[bsel] == ctl.skip_if_set) : (ctl.fsz && res == '0);
    end

    pic_call_stack #(.PC_W(PC_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (do_exec && ctl.call),
        .pop       (do_exec && ctl.ret),
        .push_data (pc_q),
        .top       (stk_top),
        .empty     (stk_empty),
        .err       (stk_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            mar_q  <= '0;
            ir_q   <= '0;
            w_q    <= '0;
            res_q  <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            cy_q   <= 1'b0;
            skp_q  <= 1'b0;
            skip_q <= 1'b0;
        end else begin
            if (do_fetch) begin
                mar_q <= pc_q;
                pc_q  <= pc_q + PC_W'(1);
            end
            if (do_decode) begin
                ir_q   <= skip_q ? INSN_NOP : bus.rom_data;
                skip_q <= 1'b0;
            end
            if (do_exec) begin
                res_q <= res;
                cy_q  <= cy;
                skp_q <= skp;
                if (ctl.jump)     pc_q <= ir_q[PC_W-1:0];
                else if (ctl.ret) pc_q <= stk_empty ? '0 : stk_top;
            end
            if (do_wb) begin
                if (ctl.wr_w)  w_q <= res_q;
                if (ctl.upd_z) z_q <= (res_q == '0);
                if (ctl.upd_c) c_q <= cy_q;
                skip_q <= skp_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wb && ctl.wr_f && !rst) ram[fa] <= res_q;
    end

    assign bus.rom_addr  = mar_q;
    assign bus.w_q       = w_q;
    assign bus.pc_q      = pc_q;
    assign bus.status_z  = z_q;
    assign bus.status_c  = c_q;
    assign bus.stack_err = stk_err;
    assign bus.retire    = do_wb;
endmodule
